ram_mem_be: RTL and testbench

- Parametrised simple-dual-port synchronous RAM with per-byte write enables and a configurable read pipeline depth (1 or 2 cycles).
- Read-during-write to the same address forwards the new data (write-first).
- Hardware clear sequencer: zero-fills (or CLR_VAL-fills) the array after reset or on request.
- Drop-in storage for the lab datapaths where contents must be deterministic without a preload file.

---
 rtl/ram_mem_pkg.sv | 43 ++++
 rtl/ram_mem_array.sv | 54 +++++
 rtl/ram_mem_be.sv | 187 ++++++++++++++++++
 tb/tb_ram_mem_be.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_mem_pkg.sv
// ram_mem_pkg: shared state type, lane-merge helper and configuration check
// for the ram_mem_be byte-enable RAM.
package ram_mem_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   // Widest data word the lane-merge helper can handle.
   localparam int MAX_DW = 1024;

   // Merge two words lane by lane: lanes whose be bit is set come from new_w,
   // all other lanes keep old_w. Callers zero-extend to MAX_DW and truncate the
   // result back to their own DW; bw is the lane width in bits.
   function automatic logic [MAX_DW-1:0] lane_merge(
      input logic [MAX_DW-1:0] old_w,
      input logic [MAX_DW-1:0] new_w,
      input logic [MAX_DW-1:0] be,
      input int                bw
   );
      logic [MAX_DW-1:0] lane_ones;
      logic [MAX_DW-1:0] mask;
      logic [MAX_DW-1:0] be_sh;
      lane_ones = (MAX_DW'(1) << bw) - MAX_DW'(1);
      mask      = '0;
      be_sh     = be;
      for (int k = 0; k * bw < MAX_DW; k++) begin
         if (be_sh[0]) begin
            mask = mask | (lane_ones << (k * bw));
         end
         be_sh = be_sh >> 1;
      end
      return (new_w & mask) | (old_w & ~mask);
   endfunction

   // Legal geometry: whole lanes only, fits the helper, latency of 1 or 2.
   function automatic bit cfg_ok(input int dw, input int bw, input int rd_lat);
      return (bw > 0) && (dw > 0) && (dw <= MAX_DW) && (dw % bw == 0) &&
             ((rd_lat == 1) || (rd_lat == 2));
   endfunction

endpackage

// File: rtl/ram_mem_array.sv
// ram_mem_array: 2**AW x DW storage with a byte-enable write port and a
// registered read port that holds its value when no read is issued.
module ram_mem_array #(
   parameter int AW = 8,
   parameter int DW = 32,
   parameter int BW = 8,
   parameter int NB = DW / BW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [NB-1:0] wbe,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdata_d;
   logic [DW-1:0] rdata_q;

   // Byte-lane write port.
   // NOTE: the array has no reset term so it maps onto RAM; contents are made
   // deterministic by the clear sweep in the parent instead.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
               mem[waddr][i*BW +: BW] <= wdata[i*BW +: BW];
            end
         end
      end
   end

   // Capture the addressed word on a read, otherwise hold the last one.
   always_comb begin
      rdata_d = re ? mem[raddr] : rdata_q;
   end

   // Read register; it sees pre-write contents on a same-edge write.
   // NOTE: clocked state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_mem_be.sv
// ram_mem_be: simple-dual-port RAM with byte enables, write-first collision
// forwarding, 1- or 2-cycle read latency and a hardware clear sweep that
// fills every word with CLR_VAL after reset or on clr_req.
// Optional write logging is compiled in when RAM_MEM_FILE_LOG_EN is defined.
module ram_mem_be #(
   parameter int            AW       = 8,
   parameter int            DW       = 32,
   parameter int            BW       = 8,
   parameter int            RD_LAT   = 1,
   parameter logic [DW-1:0] CLR_VAL  = '0,
   parameter                LOG_FILE = "ram_wr.log"
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_req,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [DW-1:0]      wr_data,
   input  logic [DW/BW-1:0]   wr_be,
   input  logic               rd_en,
   input  logic [AW-1:0]      rd_addr,
   output logic [DW-1:0]      rd_data,
   output logic               rd_valid,
   output logic               busy
);

   import ram_mem_pkg::*;

   localparam int NB = DW / BW;

   if (!cfg_ok(DW, BW, RD_LAT)) begin : g_bad_cfg
      $error("ram_mem_be: DW must be a multiple of BW and RD_LAT must be 1 or 2");
   end

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          wr_acc, rd_acc;
   logic          arr_we;
   logic [AW-1:0] arr_waddr;
   logic [DW-1:0] arr_wdata;
   logic [NB-1:0] arr_wbe;
   logic [DW-1:0] arr_rdata;
   logic          s1_valid_q, s1_valid_d;
   logic [NB-1:0] fwd_be_q, fwd_be_d;
   logic [DW-1:0] fwd_data_q, fwd_data_d;
   logic [DW-1:0] s1_word;

   // User accesses only count while the array is not being cleared.
   assign wr_acc = wr_en && (state_q == READY);
   assign rd_acc = rd_en && (state_q == READY);

   // Sweep sequencer next state: walk every address once, then serve users.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            if (&cnt_q) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         READY: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = CLEAR;
      endcase
      busy_d = (state_d == CLEAR);
   end

   // Sequencer state, sweep counter and registered busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;

   // Write-port mux: the sweep owns the port while clearing.
   always_comb begin
      arr_we    = wr_acc;
      arr_waddr = wr_addr;
      arr_wdata = wr_data;
      arr_wbe   = wr_be;
      if (state_q == CLEAR) begin
         arr_we    = 1'b1;
         arr_waddr = cnt_q;
         arr_wdata = CLR_VAL;
         arr_wbe   = '1;
      end
   end

   ram_mem_array #(
      .AW (AW),
      .DW (DW),
      .BW (BW),
      .NB (NB)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .wbe   (arr_wbe),
      .re    (rd_acc),
      .raddr (rd_addr),
      .rdata (arr_rdata)
   );

   // Stage-1 forward capture: a same-address write supplies its enabled lanes.
   always_comb begin
      s1_valid_d = rd_acc;
      fwd_be_d   = fwd_be_q;
      fwd_data_d = fwd_data_q;
      if (rd_acc) begin
         fwd_be_d   = (wr_acc && (wr_addr == rd_addr)) ? wr_be : '0;
         fwd_data_d = wr_data;
      end
   end

   // Stage-1 registers alongside the array read register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         fwd_be_q   <= '0;
         fwd_data_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         fwd_be_q   <= fwd_be_d;
         fwd_data_q <= fwd_data_d;
      end
   end

   assign s1_word = DW'(lane_merge(MAX_DW'(arr_rdata), MAX_DW'(fwd_data_q),
                                   MAX_DW'(fwd_be_q), BW));

   if (RD_LAT == 2) begin : g_lat2
      logic [DW-1:0] rd_data_q, rd_data_d;
      logic          rd_valid_q, rd_valid_d;

      // Second stage loads only when stage 1 carries a read, so data holds.
      always_comb begin
         rd_data_d  = s1_valid_q ? s1_word : rd_data_q;
         rd_valid_d = s1_valid_q;
      end

      // Second read stage registers.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
   end else begin : g_lat1
      assign rd_data  = s1_word;
      assign rd_valid = s1_valid_q;
   end

`ifdef RAM_MEM_FILE_LOG_EN
   // One line per accepted user write; sweep writes are not logged.
   always @(posedge clk) begin
      if (wr_acc) begin
         $display("%s: %h %h %h", LOG_FILE, wr_addr, wr_be, wr_data);
      end
   end
`endif

endmodule

// File: tb/tb_ram_mem_be.sv
// tb_ram_mem_be: drives one RD_LAT=1 and one RD_LAT=2 instance with shared
// stimulus and compares both against a word-level memory model every cycle.
module tb_ram_mem_be;

   localparam int AW     = 8;
   localparam int DW     = 32;
   localparam int BW     = 8;
   localparam int NB     = DW / BW;
   localparam int NWORDS = 2**AW;
   localparam logic [DW-1:0] CLR = '0;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clr_req = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [NB-1:0] wr_be = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data1, rd_data2;
   logic          rd_valid1, rd_valid2, busy1, busy2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ram_mem_be #(.AW(AW), .DW(DW), .BW(BW), .RD_LAT(1), .CLR_VAL(CLR)) u_dut_l1 (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
   );

   ram_mem_be #(.AW(AW), .DW(DW), .BW(BW), .RD_LAT(2), .CLR_VAL(CLR)) u_dut_l2 (
      .clk(clk), .rst(rst), .clr_req(clr_req),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data2), .rd_valid(rd_valid2), .busy(busy2)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rd_t;

   logic [DW-1:0] mem_m [NWORDS];
   rd_t           pend1[$];
   rd_t           pend2[$];
   int            sweep_left = 0;
   int            cyc = 0;
   bit            chk_en = 0;
   bit            exp_v1 = 0, exp_v2 = 0;
   logic [DW-1:0] exp_d1 = '0, exp_d2 = '0;

   task automatic model_fill();
      for (int i = 0; i < NWORDS; i++) mem_m[i] = CLR;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_left = NWORDS;
         pend1.delete();
         pend2.delete();
         exp_v1 = 0;
         exp_v2 = 0;
         exp_d1 = '0;
         exp_d2 = '0;
         model_fill();
         chk_en = 1;
      end else begin
         cyc++;
         if (sweep_left > 0) begin
            sweep_left--;
         end else begin
            if (wr_en) begin
               for (int b = 0; b < NB; b++)
                  if (wr_be[b]) mem_m[wr_addr][b*BW +: BW] = wr_data[b*BW +: BW];
            end
            if (rd_en) begin
               pend1.push_back('{cyc, mem_m[rd_addr]});
               pend2.push_back('{cyc + 1, mem_m[rd_addr]});
            end
            if (clr_req) begin
               sweep_left = NWORDS;
               model_fill();
            end
         end
         exp_v1 = 0;
         if (pend1.size() > 0 && pend1[0].due == cyc) begin
            exp_v1 = 1;
            exp_d1 = pend1[0].data;
            void'(pend1.pop_front());
         end
         exp_v2 = 0;
         if (pend2.size() > 0 && pend2[0].due == cyc) begin
            exp_v2 = 1;
            exp_d2 = pend2[0].data;
            void'(pend2.pop_front());
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_busy_l1",  busy1,     sweep_left > 0);
         check("cyc_busy_l2",  busy2,     sweep_left > 0);
         check("cyc_valid_l1", rd_valid1, exp_v1);
         check("cyc_valid_l2", rd_valid2, exp_v2);
         check("cyc_data_l1",  rd_data1,  exp_d1);
         check("cyc_data_l2",  rd_data2,  exp_d2);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NB-1:0] be, input bit re, input logic [AW-1:0] ra,
                        input bit clr);
      wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rd_en = re; rd_addr = ra; clr_req = clr;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
   endtask

   task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
      drive(1'b1, a, d, be, 1'b0, '0, 1'b0);
   endtask

   task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      drive(1'b0, '0, '0, '0, 1'b1, a, 1'b0);
      check({name, "_v_l1"}, rd_valid1, 1);
      check({name, "_d_l1"}, rd_data1, exp);
      @(negedge clk);
      check({name, "_v_l2"}, rd_valid2, 1);
      check({name, "_d_l2"}, rd_data2, exp);
   endtask

   task automatic count_busy(input string name);
      int n;
      n = 0;
      while (busy1 === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, n, NWORDS);
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      int n;
      int vcnt;

      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", busy1, 1);
      check("rst_valid_l1", rd_valid1, 0);
      check("rst_data_l1", rd_data1, 0);
      check("rst_data_l2", rd_data2, 0);
      rst = 1'b0;
      count_busy("boot_busy_cycles");

      read_chk("boot_rd0", 8'd0, 32'h0);
      read_chk("boot_rd128", 8'd128, 32'h0);
      read_chk("boot_rd255", 8'd255, 32'h0);

      write(8'd5, 32'hDEADBEEF, 4'b1111);
      write(8'd5, 32'h000000AA, 4'b0001);
      read_chk("be_merge", 8'd5, 32'hDEADBEAA);

      write(8'd9, 32'hAABBCCDD, 4'b1111);
      drive(1'b1, 8'd9, 32'h12345678, 4'b1100, 1'b1, 8'd9, 1'b0);
      check("collide_v_l1", rd_valid1, 1);
      check("collide_d_l1", rd_data1, 32'h1234CCDD);
      @(negedge clk);
      check("collide_v_l2", rd_valid2, 1);
      check("collide_d_l2", rd_data2, 32'h1234CCDD);

      // Write one cycle after a read: the RD_LAT=2 read still sees old data.
      rd_en = 1'b1; rd_addr = 8'd9;
      @(negedge clk);
      check("late_wr_d_l1", rd_data1, 32'h1234CCDD);
      rd_en = 1'b0;
      wr_en = 1'b1; wr_addr = 8'd9; wr_data = 32'h0; wr_be = 4'b1111;
      @(negedge clk);
      wr_en = 1'b0;
      check("late_wr_v_l2", rd_valid2, 1);
      check("late_wr_d_l2", rd_data2, 32'h1234CCDD);
      read_chk("late_wr_after", 8'd9, 32'h0);

      for (int i = 0; i < 16; i++) write(AW'(i), DW'(i * 3), 4'b1111);
      vcnt = 0;
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1; rd_addr = AW'(i);
         @(negedge clk);
         if (rd_valid1 === 1'b1) vcnt++;
         check("stream_d_l1", rd_data1, DW'(i * 3));
      end
      rd_en = 1'b0;
      check("stream_valid_count", vcnt, 16);
      @(negedge clk);

      for (int k = 0; k < 600; k++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = AW'($urandom_range(0, 15));
         wr_data = $urandom();
         wr_be   = NB'($urandom_range(0, 15));
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 15));
         clr_req = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
      n = 0;
      while (busy1 === 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("rand_settle", busy1, 0);

      write(8'd7, 32'h55, 4'b1111);
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      n = 0;
      vcnt = 0;
      while (busy1 === 1'b1 && n < 2000) begin
         if (n < 10) begin
            wr_en = 1'b1; wr_addr = 8'd7; wr_data = 32'hFFFFFFFF; wr_be = '1;
            rd_en = 1'b1; rd_addr = 8'd7; clr_req = (n == 3);
         end else begin
            wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
         end
         @(negedge clk);
         n++;
         if (rd_valid1 === 1'b1 || rd_valid2 === 1'b1) vcnt++;
      end
      wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
      check("clr_busy_cycles", n, NWORDS);
      check("clr_no_valid", vcnt, 0);
      read_chk("clr_addr7", 8'd7, CLR);

      // Reset in the middle of a sweep.
      drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
      repeat (100) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_sweep_busy", busy1, 1);
      check("mid_sweep_valid_l2", rd_valid2, 0);
      @(negedge clk);
      rst = 1'b0;
      count_busy("mid_sweep_busy_cycles");

      // Reset with a read in flight.
      write(8'd5, 32'hCAFEF00D, 4'b1111);
      rd_en = 1'b1; rd_addr = 8'd5;
      @(posedge clk);
      #1 rst = 1'b1;
      rd_en = 1'b0;
      @(negedge clk);
      check("flight_valid_l1", rd_valid1, 0);
      check("flight_data_l1", rd_data1, 0);
      check("flight_valid_l2", rd_valid2, 0);
      check("flight_data_l2", rd_data2, 0);
      @(negedge clk);
      check("flight_valid_l2_late", rd_valid2, 0);
      rst = 1'b0;
      count_busy("flight_busy_cycles");
      read_chk("flight_after", 8'd5, CLR);

      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
